// File: rtl/axis_fifo_pkg.sv
// Shared types and sizing helpers for the AXI4-Stream packet FIFO.
// Entries are packed as {tlast, tstrb, tdata}.
package axis_fifo_pkg;

  typedef enum logic {
    PASS = 1'b0,
    DROP = 1'b1
  } fifo_state_t;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int entry_width(input int data_width);
    return data_width + data_width / 8 + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port buffer: one write port, one registered read port.
// The read register doubles as the FIFO output register, so it holds when not enabled.
module axis_fifo_ram
  import axis_fifo_pkg::*;
#(
  parameter int WIDTH = entry_width(32),
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [1 << AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_packet_fifo.sv
// Single-clock AXI4-Stream FIFO with cut-through or store-and-forward release,
// discarding packets that can never fit instead of deadlocking.
module axis_packet_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 512,
  parameter int PACKET_MODE = 0
) (
  input  logic                      s00_axis_aclk,
  input  logic                      s00_axis_aresetn,
  input  logic [DATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s00_axis_tstrb,
  input  logic                      s00_axis_tvalid,
  input  logic                      s00_axis_tlast,
  output logic                      s00_axis_tready,
  output logic [DATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                      m00_axis_tvalid,
  output logic                      m00_axis_tlast,
  input  logic                      m00_axis_tready,
  output logic [$clog2(DEPTH):0]    level,
  output logic [$clog2(DEPTH):0]    pkt_count,
  output logic                      drop
);

  localparam int AW = addr_width(DEPTH);
  localparam int EW = entry_width(DATA_WIDTH);
  localparam bit PKT = (PACKET_MODE != 0);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  fifo_state_t state, state_next;
  logic [AW:0] wr_ptr, wr_commit, rd_ptr, fetch_ptr, limit_ptr, pkt_cnt;
  logic        ready_en, out_valid, full, accept, store, xfer, rd_en;
  logic        drop_cond, drop_next, rewind;
  logic [EW-1:0] wr_entry, rd_entry;

  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Full with no complete packet buffered means the current packet is oversize.
  assign drop_cond = PKT && full && (pkt_cnt == '0);

  assign s00_axis_tready = ready_en && (!full || drop_cond || state == DROP);
  assign accept = s00_axis_tvalid && s00_axis_tready;
  assign store  = accept && (state == PASS) && !full;
  assign xfer   = out_valid && m00_axis_tready;

  // The output register holds the head entry, so the next fetch is one past it.
  assign fetch_ptr = rd_ptr + {{AW{1'b0}}, out_valid};
  assign limit_ptr = PKT ? wr_commit : wr_ptr;
  assign rd_en     = (fetch_ptr != limit_ptr) && (!out_valid || m00_axis_tready);

  assign wr_entry = {s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata};

  always_comb begin
    state_next = state;
    drop_next  = 1'b0;
    rewind     = 1'b0;
    case (state)
      PASS: begin
        if (drop_cond) begin
          rewind = 1'b1;
          if (accept && s00_axis_tlast) drop_next  = 1'b1;
          else                          state_next = DROP;
        end
      end
      DROP: begin
        if (accept && s00_axis_tlast) begin
          drop_next  = 1'b1;
          state_next = PASS;
        end
      end
      default: state_next = PASS;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state     <= PASS;
      drop      <= 1'b0;
      ready_en  <= 1'b0;
      out_valid <= 1'b0;
      wr_ptr    <= '0;
      wr_commit <= '0;
      rd_ptr    <= '0;
      pkt_cnt   <= '0;
    end else begin
      state    <= state_next;
      drop     <= drop_next;
      ready_en <= 1'b1;
      if (rewind)     wr_ptr <= wr_commit;
      else if (store) wr_ptr <= wr_ptr + ONE;
      if (store && s00_axis_tlast) wr_commit <= wr_ptr + ONE;
      if (xfer) rd_ptr <= rd_ptr + ONE;
      if (rd_en)                out_valid <= 1'b1;
      else if (m00_axis_tready) out_valid <= 1'b0;
      case ({store && s00_axis_tlast, xfer && m00_axis_tlast})
        2'b10:   pkt_cnt <= pkt_cnt + ONE;
        2'b01:   pkt_cnt <= pkt_cnt - ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  axis_fifo_ram #(
    .WIDTH (EW),
    .AW    (AW)
  ) u_ram (
    .clk     (s00_axis_aclk),
    .rst_n   (s00_axis_aresetn),
    .wr_en   (store),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_addr (fetch_ptr[AW-1:0]),
    .rd_data (rd_entry)
  );

  assign {m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata} = rd_entry;
  assign m00_axis_tvalid = out_valid;
  assign level           = wr_ptr - rd_ptr;
  assign pkt_count       = pkt_cnt;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Randomised bench for axis_packet_fifo: three instances (stream/16, packet/512,
// packet/16) checked against a packet-level queue model.
module tb_axis_packet_fifo;

  typedef logic [36:0] beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_tdata [3];
  logic [3:0]  s_tstrb [3];
  logic        s_tvalid [3];
  logic        s_tlast [3];
  logic        s_tready [3];
  logic [31:0] m_tdata [3];
  logic [3:0]  m_tstrb [3];
  logic        m_tvalid [3];
  logic        m_tlast [3];
  logic        m_tready [3];
  logic        drop_o [3];
  logic [9:0]  level_w [3];
  logic [9:0]  pkt_w [3];

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode [3];

  beat_t expq [3][$];
  beat_t partq [3][$];
  int    drop_exp [3];
  int    drops_seen [3];
  int    first_acc [3];
  int    first_vld [3];
  logic  stall_prev [3];
  beat_t stall_beat [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D  = (g == 1) ? 512 : 16;
    localparam int PM = (g == 0) ? 0 : 1;
    logic [$clog2(D):0] lv, pc;
    axis_packet_fifo #(.DATA_WIDTH(32), .DEPTH(D), .PACKET_MODE(PM)) u_dut (
      .s00_axis_aclk    (clk),
      .s00_axis_aresetn (rst_n),
      .s00_axis_tdata   (s_tdata[g]),
      .s00_axis_tstrb   (s_tstrb[g]),
      .s00_axis_tvalid  (s_tvalid[g]),
      .s00_axis_tlast   (s_tlast[g]),
      .s00_axis_tready  (s_tready[g]),
      .m00_axis_tdata   (m_tdata[g]),
      .m00_axis_tstrb   (m_tstrb[g]),
      .m00_axis_tvalid  (m_tvalid[g]),
      .m00_axis_tlast   (m_tlast[g]),
      .m00_axis_tready  (m_tready[g]),
      .level            (lv),
      .pkt_count        (pc),
      .drop             (drop_o[g])
    );
    assign level_w[g] = 10'(lv);
    assign pkt_w[g]   = 10'(pc);
  end

  function automatic int depth_of(input int i);
    return (i == 1) ? 512 : 16;
  endfunction

  function automatic bit is_pkt(input int i);
    return i != 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    for (int i = 0; i < 3; i++) m_tready[i] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++)
        m_tready[i] = (rdy_mode[i] == 1) ? 1'b1 :
                      (rdy_mode[i] == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Reference model: stream beats go straight to the expected queue; packet
  // beats wait until tlast, and a packet longer than the buffer is dropped.
  initial forever begin
    beat_t got, b;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        expq[i].delete();
        partq[i].delete();
        drop_exp[i]   = 0;
        drops_seen[i] = 0;
        first_acc[i]  = -1;
        first_vld[i]  = -1;
        stall_prev[i] = 1'b0;
      end else begin
        got = {m_tlast[i], m_tstrb[i], m_tdata[i]};
        if (stall_prev[i]) begin
          check($sformatf("hold_valid[%0d]", i), m_tvalid[i], 1);
          check($sformatf("hold_beat[%0d]", i), got, stall_beat[i]);
        end
        if (m_tvalid[i]) begin
          if (first_vld[i] < 0) first_vld[i] = cyc;
          check($sformatf("valid_has_data[%0d]", i), expq[i].size() != 0, 1);
          if (m_tready[i] && expq[i].size() != 0)
            check($sformatf("beat[%0d]", i), got, expq[i].pop_front());
        end
        stall_prev[i] = m_tvalid[i] && !m_tready[i];
        stall_beat[i] = got;
        if (s_tvalid[i] && s_tready[i]) begin
          b = {s_tlast[i], s_tstrb[i], s_tdata[i]};
          if (first_acc[i] < 0) first_acc[i] = cyc;
          if (!is_pkt(i)) expq[i].push_back(b);
          else begin
            partq[i].push_back(b);
            if (s_tlast[i]) begin
              if (partq[i].size() > depth_of(i)) drop_exp[i]++;
              else while (partq[i].size() != 0) expq[i].push_back(partq[i].pop_front());
              partq[i].delete();
            end
          end
        end
        if (drop_o[i]) begin
          drops_seen[i]++;
          check($sformatf("drop_expected[%0d]", i), drop_exp[i] > 0, 1);
          if (drop_exp[i] > 0) drop_exp[i]--;
        end
      end
    end
  end

  task automatic drive_beat(input int i, input logic [31:0] d, input logic [3:0] st, input logic last);
    bit ok = 1'b0;
    s_tvalid[i] = 1'b1;
    s_tdata[i]  = d;
    s_tstrb[i]  = st;
    s_tlast[i]  = last;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      if (s_tready[i]) ok = 1'b1;
    end
    if (!ok) check($sformatf("accept_timeout[%0d]", i), 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int i, input int len, input int nbeats, input bit fixed, input logic [31:0] fd);
    for (int b = 0; b < nbeats; b++)
      drive_beat(i, fixed ? fd : $urandom, fixed ? 4'hF : 4'($urandom), b == len - 1);
    s_tvalid[i] = 1'b0;
    s_tlast[i]  = 1'b0;
  endtask

  task automatic wait_drain(input int i, input string tag);
    bit done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      if (!m_tvalid[i] && level_w[i] == 0 && expq[i].size() == 0) done = 1'b1;
    end
    check({tag, "_drained"}, done, 1);
    check({tag, "_pkt_count"}, pkt_w[i], 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0; s_tdata[i] = '0; s_tstrb[i] = '0;
      rdy_mode[i] = 1;
    end

    // Test 1: reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_tready[%0d]", i), s_tready[i], 0);
      check($sformatf("rst_tvalid[%0d]", i), m_tvalid[i], 0);
      check($sformatf("rst_level[%0d]", i), level_w[i], 0);
    end
    check("rst_tdata", m_tdata[0], 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_tready_before_edge", s_tready[0], 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("rel_tready[%0d]", i), s_tready[i], 1);

    // Test 2: stream, four beats
    for (int v = 1; v <= 4; v++) drive_beat(0, 32'(v), 4'hF, v == 4);
    s_tvalid[0] = 1'b0; s_tlast[0] = 1'b0;
    wait_drain(0, "t2");
    check("t2_latency", 64'(first_vld[0] - first_acc[0]), 2);

    // Test 3: 256-beat store-and-forward packet
    send_pkt(1, 256, 256, 1'b1, 32'h2288AA22);
    check("t3_pkt_count_1", pkt_w[1], 1);
    check("t3_level_256", level_w[1], 256);
    check("t3_not_yet_valid", m_tvalid[1], 0);
    repeat (257) @(posedge clk);
    #1;
    check("t3_level_0", level_w[1], 0);
    check("t3_pkt_count_0", pkt_w[1], 0);
    check("t3_idle", m_tvalid[1], 0);
    wait_drain(1, "t3");

    // Test 4: backpressure to full, then random release
    rdy_mode[0] = 0;
    @(posedge clk);
    #1;
    for (int b = 0; b < 16; b++) drive_beat(0, $urandom, 4'($urandom), 1'b0);
    s_tvalid[0] = 1'b1; s_tdata[0] = $urandom; s_tstrb[0] = 4'hF; s_tlast[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_tready_low", s_tready[0], 0);
    check("t4_level_full", level_w[0], 16);
    rdy_mode[0] = 2;
    drive_beat(0, s_tdata[0], s_tstrb[0], 1'b0);
    for (int b = 18; b <= 20; b++) drive_beat(0, $urandom, 4'($urandom), b == 20);
    s_tvalid[0] = 1'b0; s_tlast[0] = 1'b0;
    wait_drain(0, "t4");

    // Test 5: oversize packet dropped, next packet intact
    rdy_mode[2] = 2;
    c0 = cyc;
    send_pkt(2, 20, 20, 1'b0, 32'h0);
    check("t5_never_stalled", 64'(cyc - c0), 20);
    repeat (2) @(posedge clk);
    #1;
    check("t5_one_drop", drops_seen[2], 1);
    check("t5_level_0", level_w[2], 0);
    send_pkt(2, 4, 4, 1'b0, 32'h0);
    wait_drain(2, "t5");
    check("t5_drop_total", drops_seen[2], 1);
    check("t5_no_pending_drop", drop_exp[2], 0);

    // Test 6: reset mid-packet
    rdy_mode[1] = 2;
    send_pkt(1, 256, 100, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("t6_tready", s_tready[1], 0);
    check("t6_tvalid", m_tvalid[1], 0);
    check("t6_level", level_w[1], 0);
    check("t6_pkt_count", pkt_w[1], 0);
    check("t6_drop", drop_o[1], 0);
    check("t6_tdata", m_tdata[1], 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_pkt(1, 8, 8, 1'b0, 32'h0);
    wait_drain(1, "t6");
    check("t6_no_drop", drops_seen[1], 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
